// File: rtl/reg_bank_wb.sv
// Write-back end of the destination-register path: a 1-entry pending stage in front of the
// register array, with two bypassing read ports and pending-entry visibility for hazard checks.
module reg_bank_wb #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 5,
  parameter int unsigned       SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(227)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              hold,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];

  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;

  logic accept;
  logic commit;

  // wr_ready depends only on stage occupancy and hold, never on reset.
  assign wr_ready = !pend_valid_q || !hold;
  assign accept   = wr_valid && wr_ready;
  assign commit   = pend_valid_q && !hold;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (commit) begin
      pend_valid_d = 1'b0;
      pend_addr_d  = '0;
      pend_data_d  = '0;
    end
    // A write to index 0 completes its handshake but never occupies the stage.
    if (accept && (wr_addr != '0)) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = wr_addr;
      pend_data_d  = wr_data;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[pend_addr_q] = pend_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      regs_q       <= regs_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] data;
    data = '0;
    if (addr == '0) begin
      data = '0;
    end else if (pend_valid_q && (addr == pend_addr_q)) begin
      data = pend_data_q;
    end else begin
      data = regs_q[addr];
    end
    return data;
  endfunction

  assign rd_data_a  = read_port(rd_addr_a);
  assign rd_data_b  = read_port(rd_addr_b);
  assign pend_valid = pend_valid_q;
  assign pend_addr  = pend_addr_q;

endmodule
